// File: rtl/mips_mem_pkg.sv
// Shared definitions for the load/store unit and its lane alignment helper.
//   - request size encodings (SZ_BYTE / SZ_HALF / SZ_WORD)
//   - FSM state enum
//   - WORD_ADDR_W: width of the data memory word address (256 words)
package mips_mem_pkg;

  localparam int WORD_ADDR_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // A half is misaligned on an odd address, a word on any non-zero lane.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_HALF: is_misaligned = lane[0];
      SZ_WORD: is_misaligned = |lane;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane helper for the load/store unit.
// Ports:
//   i_word     - word read from memory
//   i_size     - normalised size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   i_lane     - byte address bits [1:0]
//   i_unsigned - zero-extend loaded byte/half instead of sign-extending
//   i_wdata    - right-justified store data
//   o_load     - selected lane, right-justified and extended
//   o_merge    - i_word with the selected lane replaced by store data
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_word[{i_lane, 3'b000} +: 8];
    w_half  = i_word[{i_lane[1], 4'b0000} +: 16];
    o_load  = i_word;
    o_merge = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_load = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
        o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
        o_merge[{i_lane[1], 4'b0000} +: 16] = i_wdata[15:0];
      end
      default: begin
        o_load  = i_word;
        o_merge = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: MEM-stage initiator for a 256 x 32 word memory with
// combinational read and synchronous write. Sub-word stores use
// read-modify-write. Loads return sign/zero-extended data.
//
// Optional: define LSU_MISALIGN_TRAP_EN to answer misaligned half/word
// requests with resp_err=1 and no memory access. Without it the low address
// bits are forced to lane alignment and resp_err stays 0.
//
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   req_*             - request (valid/ready; wr, size, unsigned, addr, wdata)
//   resp_*            - one-cycle response pulse, load data, misalign flag
//   mem_rd_addr/data  - memory read port
//   mem_wr_addr/data/en - memory write port
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | ready for a request
// ST_READ  | memory read of the latched word address
// ST_WRITE | mem_wr_en high for one cycle
// ST_RESP  | resp_valid high for one cycle
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [ADDR_W-3:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_en
);

  lsu_state_t        r_state;
  logic              r_wr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic [ADDR_W-3:0] r_mem_rd_addr;
  logic [ADDR_W-3:0] r_mem_wr_addr;
  logic [DATA_W-1:0] r_mem_wr_data;
  logic              r_mem_wr_en;

  logic [1:0]        w_size_n;
  logic [ADDR_W-1:0] w_addr_eff;
  logic              w_misalign;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merge;

  // Size 11 behaves exactly like a word access.
  assign w_size_n = (req_size == 2'b11) ? SZ_WORD : req_size;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(w_size_n, req_addr[1:0]);
  assign w_addr_eff = req_addr;
`else
  assign w_misalign = 1'b0;
  always_comb begin
    w_addr_eff = req_addr;
    if (w_size_n == SZ_HALF) w_addr_eff[0]   = 1'b0;
    if (w_size_n == SZ_WORD) w_addr_eff[1:0] = 2'b00;
  end
`endif

  mem_lane_align u_align (
    .i_word     (mem_rd_data),
    .i_size     (r_size),
    .i_lane     (r_addr[1:0]),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_wr          <= 1'b0;
      r_size        <= SZ_BYTE;
      r_unsigned    <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= '0;
      r_resp_err    <= 1'b0;
      r_mem_rd_addr <= '0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
      r_mem_wr_en   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_mem_wr_en  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_wr       <= req_wr;
            r_size     <= w_size_n;
            r_unsigned <= req_unsigned;
            r_addr     <= w_addr_eff;
            r_wdata    <= req_wdata;
            if (w_misalign) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else if (req_wr && (w_size_n == SZ_WORD)) begin
              r_state       <= ST_WRITE;
              r_mem_wr_en   <= 1'b1;
              r_mem_wr_addr <= w_addr_eff[ADDR_W-1:2];
              r_mem_wr_data <= req_wdata;
            end else begin
              r_state       <= ST_READ;
              r_mem_rd_addr <= w_addr_eff[ADDR_W-1:2];
            end
          end
        end
        ST_READ: begin
          // Memory data is valid this cycle; capture it as merge or load result.
          if (r_wr) begin
            r_state       <= ST_WRITE;
            r_mem_wr_en   <= 1'b1;
            r_mem_wr_addr <= r_addr[ADDR_W-1:2];
            r_mem_wr_data <= w_merge;
          end else begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_load;
          end
        end
        ST_WRITE: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_resp_err;
  assign mem_rd_addr = r_mem_rd_addr;
  assign mem_wr_addr = r_mem_wr_addr;
  assign mem_wr_data = r_mem_wr_data;
  assign mem_wr_en   = r_mem_wr_en;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [7:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_en;

  logic [31:0] mem [0:255];

  int n_assert = 0;
  int n_fail   = 0;

  logic [4:1]  cap_rv;
  logic [4:1]  cap_we;
  logic [31:0] cap_rdata;
  logic [31:0] cap_err;
  logic [31:0] cap_wa;
  logic [31:0] cap_wd;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_en    (mem_wr_en)
  );

  assign mem_rd_data = mem[mem_rd_addr];

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] = mem_wr_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request and records four cycles of DUT activity after acceptance.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [9:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    cap_rv = '0; cap_we = '0;
    cap_rdata = 32'hBAD0BAD0; cap_err = 32'hBAD0BAD0;
    cap_wa = 32'hBAD0BAD0; cap_wd = 32'hBAD0BAD0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cap_rv[k] = resp_valid;
      cap_we[k] = mem_wr_en;
      if (mem_wr_en) begin
        cap_wa = {24'b0, mem_wr_addr};
        cap_wd = mem_wr_data;
      end
      if (resp_valid) begin
        cap_rdata = resp_rdata;
        cap_err   = {31'b0, resp_err};
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
    check("rst_rd_addr", {24'b0, mem_rd_addr}, 32'd0);
    check("rst_wr_addr", {24'b0, mem_wr_addr}, 32'd0);
    check("rst_wr_data", mem_wr_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);

    // lw 0x010
    run_req("lw", 1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    check("lw_rv", {28'b0, cap_rv}, 32'b0010);
    check("lw_we", {28'b0, cap_we}, 32'b0000);
    check("lw_rdata", cap_rdata, 32'h8899AABB);
    check("lw_err", cap_err, 32'd0);
    check("lw_rd_addr", {24'b0, mem_rd_addr}, 32'h04);

    // byte / half loads
    run_req("lb", 1'b0, 2'b00, 1'b0, 10'h013, 32'h0);
    check("lb_rv", {28'b0, cap_rv}, 32'b0010);
    check("lb_rdata", cap_rdata, 32'hFFFFFF88);
    run_req("lbu", 1'b0, 2'b00, 1'b1, 10'h013, 32'h0);
    check("lbu_rdata", cap_rdata, 32'h00000088);
    run_req("lb1", 1'b0, 2'b00, 1'b0, 10'h011, 32'h0);
    check("lb1_rdata", cap_rdata, 32'hFFFFFFAA);
    run_req("lh", 1'b0, 2'b01, 1'b0, 10'h010, 32'h0);
    check("lh_rdata", cap_rdata, 32'hFFFFAABB);
    run_req("lhu", 1'b0, 2'b01, 1'b1, 10'h012, 32'h0);
    check("lhu_rdata", cap_rdata, 32'h00008899);
    run_req("lw11", 1'b0, 2'b11, 1'b1, 10'h010, 32'h0);
    check("lw11_rdata", cap_rdata, 32'h8899AABB);

    // misaligned word load
    run_req("lwmis", 1'b0, 2'b10, 1'b0, 10'h011, 32'h0);
    check("lwmis_we", {28'b0, cap_we}, 32'b0000);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lwmis_rv", {28'b0, cap_rv}, 32'b0001);
    check("lwmis_rdata", cap_rdata, 32'h0);
    check("lwmis_err", cap_err, 32'd1);
`else
    check("lwmis_rv", {28'b0, cap_rv}, 32'b0010);
    check("lwmis_rdata", cap_rdata, 32'h8899AABB);
    check("lwmis_err", cap_err, 32'd0);
`endif

    // sh 0x012 read-modify-write
    run_req("sh", 1'b1, 2'b01, 1'b0, 10'h012, 32'h00001234);
    check("sh_we", {28'b0, cap_we}, 32'b0010);
    check("sh_rv", {28'b0, cap_rv}, 32'b0100);
    check("sh_wa", cap_wa, 32'h04);
    check("sh_wd", cap_wd, 32'h1234AABB);
    check("sh_rdata", cap_rdata, 32'h0);
    check("sh_mem", mem[4], 32'h1234AABB);

    // sb 0x011 merge into lane 1
    run_req("sb", 1'b1, 2'b00, 1'b0, 10'h011, 32'hFFFFFF5A);
    check("sb_we", {28'b0, cap_we}, 32'b0010);
    check("sb_wd", cap_wd, 32'h12345ABB);
    run_req("lwback", 1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
    check("lwback_rdata", cap_rdata, 32'h12345ABB);

    // sw 0x020 with a follow-on load held on req_valid while busy
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 10'h020; req_wdata = 32'hDEADBEEF;
    check("sw_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_wr = 1'b0; req_addr = 10'h020; req_wdata = 32'h0;
    @(negedge clk);
    check("sw_we_t1", {31'b0, mem_wr_en}, 32'd1);
    check("sw_wa", {24'b0, mem_wr_addr}, 32'h08);
    check("sw_wd", mem_wr_data, 32'hDEADBEEF);
    check("sw_busy_t1", {31'b0, req_ready}, 32'd0);
    check("sw_rv_t1", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    check("sw_rv_t2", {31'b0, resp_valid}, 32'd1);
    check("sw_we_t2", {31'b0, mem_wr_en}, 32'd0);
    check("sw_busy_t2", {31'b0, req_ready}, 32'd0);
    check("sw_mem", mem[8], 32'hDEADBEEF);
    @(negedge clk);
    check("held_ready_t3", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("held_rv_t4", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    check("held_rv_t5", {31'b0, resp_valid}, 32'd1);
    check("held_rdata", resp_rdata, 32'hDEADBEEF);

    // sb 0x010 interrupted by reset in READ
    @(negedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 10'h010; req_wdata = 32'h00000055;
    @(posedge clk);
    #1 req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_busy", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    check("rstmid_we_a", {31'b0, mem_wr_en}, 32'd0);
    check("rstmid_rv_a", {31'b0, resp_valid}, 32'd0);
    check("rstmid_ready_a", {31'b0, req_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_we_b", {31'b0, mem_wr_en}, 32'd0);
    check("rstmid_rv_b", {31'b0, resp_valid}, 32'd0);
    check("rstmid_ready_b", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    check("rstmid_we_c", {31'b0, mem_wr_en}, 32'd0);
    check("rstmid_mem", mem[4], 32'h12345ABB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
